trap_ctrl: RTL and testbench
============================

# trap_ctrl

Trap entry/exit sequencer driving the CSR file's write and read ports on behalf of the core. On an exception, interrupt or `mret` it stalls the core and performs the ordered CSR updates one per cycle: `mepc`, `mcause`, `mstatus` on entry; `mstatus` on exit. It then issues a one-cycle PC redirect, to `mtvec` on entry or `mepc` on exit. It sits between the core's commit stage and the CSR file, as the initiator of every trap-related CSR access.

## Interface
Parameters:
- `XLEN`, 32, data/PC width
- `CAUSE_W`, 4, width of synchronous exception cause code

Ports:
- `clk`  in  1  clock
- `rst`  in  1  synchronous, active-high reset
- `commit_valid`  in  1  instruction retiring this cycle
- `commit_pc`  in  XLEN  PC of next instruction (interrupt return address)
- `exc_valid`  in  1  synchronous exception on the retiring instruction
- `exc_cause`  in  CAUSE_W  exception code
- `exc_pc`  in  XLEN  faulting PC
- `mret_valid`  in  1  `mret` retiring
- `irq_ext`  in  1  level-sensitive external interrupt
- `csr_we`  out  1  CSR write strobe
- `csr_waddr`  out  12  CSR write address
- `csr_wdata`  out  XLEN  CSR write data
- `csr_raddr`  out  12  CSR read address
- `csr_rdata`  in  XLEN  combinational read data for `csr_raddr`
- `redirect_valid`  out  1  one-cycle PC redirect strobe
- `redirect_pc`  out  XLEN  redirect target
- `busy`  out  1  core must stall; inputs ignored
- `tmr_we`  in  1  write `mtimecmp` (only with `TRAP_TIMER_IRQ_EN`)
- `tmr_wdata`  in  XLEN  new `mtimecmp` (only with `TRAP_TIMER_IRQ_EN`)

## Operation
- States: IDLE, SAVE_EPC, SAVE_CAUSE, SAVE_STATUS, JUMP, RST_STATUS, RET.
- IDLE:
  - `csr_raddr`=0x300 (`mstatus`).
  - `mie_now` = `csr_rdata[3]`.
  - Events are sampled in priority order:
    1. `exc_valid` → latch epc=`exc_pc`, cause={0,`exc_cause`}
    2. `commit_valid & mie_now & irq_ext` → epc=`commit_pc`, cause=0x8000000B
    3. `commit_valid & mie_now & timer_pend` → epc=`commit_pc`, cause=0x80000007
    4. `mret_valid` → RST_STATUS
  - Cases 1–3 go to SAVE_EPC.
  - Lower-priority simultaneous events are dropped; the core re-presents them.
- SAVE_EPC: write 0x341 ← epc.
- SAVE_CAUSE: write 0x342 ← cause.
- SAVE_STATUS:
  - read 0x300, then write 0x300 ← rdata with MPIE(7)=MIE(3), MIE=0, MPP(12:11)=2'b11.
- JUMP:
  - read 0x305.
  - `redirect_valid`=1, `redirect_pc`=`csr_rdata & ~3` (direct mode only).
  - → IDLE.
- RST_STATUS: read 0x300, then write 0x300 ← rdata with MIE=MPIE, MPIE=1.
- RET:
  - read 0x341.
  - `redirect_valid`=1, `redirect_pc`=`csr_rdata & ~3`.
  - → IDLE.
- `busy` = (state != IDLE).
- `csr_we` is high only in SAVE_EPC, SAVE_CAUSE, SAVE_STATUS and RST_STATUS; at most one write per cycle.

## Timing
- Reset values: state=IDLE, `csr_we`=0, `csr_waddr`=0, `csr_wdata`=0, `redirect_valid`=0, `redirect_pc`=0, `busy`=0, latched epc/cause=0.
- Trap entry:
  - Event accepted at cycle N.
  - Writes occur at N+1 (mepc), N+2 (mcause), N+3 (mstatus).
  - Redirect at N+4.
  - `busy` is high N+1..N+4.
- `mret`:
  - Accepted at N.
  - mstatus written at N+1, redirect at N+2.
  - `busy` is high N+1..N+2.
- Next event is accepted no earlier than the cycle after the redirect.
- `rst` asserted in any state: next cycle is IDLE, all outputs at reset values, and no further CSR writes. A partially written trap frame is left as is.
- Outputs are registered from state, except `csr_raddr` (decoded from state) and `redirect_pc` (combinational from `csr_rdata` in JUMP/RET).

## Configuration
- `TRAP_TIMER_IRQ_EN` defined:
  - 32-bit `mtime` counter: reset 0, +1 per cycle, wraps at 0xFFFFFFFF→0.
  - 32-bit `mtimecmp`: reset 0xFFFFFFFF, loaded from `tmr_wdata` when `tmr_we`.
  - `timer_pend` = (`mtime` >= `mtimecmp`), unsigned.
  - `tmr_we`/`tmr_wdata` ports are present.
- Undefined: no timer logic, `timer_pend`=0, ports absent, cause 0x80000007 never produced.

## Structure
- `trap_pkg`:
  - CSR address constants (MSTATUS 0x300, MTVEC 0x305, MEPC 0x341, MCAUSE 0x342)
  - state enum
  - interrupt cause constants
  - mstatus bit positions (MIE, MPIE, MPP)
- Sub-module `trap_timer` holds `mtime`/`mtimecmp`/`timer_pend`; instantiated only under `TRAP_TIMER_IRQ_EN`.

## Test plan
The bench model returns `mstatus`=0x00000008 and `mtvec`=0x80000100.
- ECALL: `exc_valid`, cause 0xB, pc 0x80000040 → writes 0x341←0x80000040, 0x342←0x0000000B, 0x300←0x00001880 on consecutive cycles; redirect 0x80000100 at N+4.
- `mret` with `mstatus`=0x00001880, `mepc`=0x80000044 → write 0x300←0x00001888 at N+1; redirect 0x80000044 at N+2.
- `irq_ext` + `commit_valid`, `commit_pc` 0x80000010, MIE=1 → mcause 0x8000000B, mepc 0x80000010; repeat with MIE=0 → no action, `busy` stays 0.
- `exc_valid` and `mret_valid` and `irq_ext` in the same cycle → exception path only; mcause = `exc_cause`.
- `rst` pulse in SAVE_CAUSE → next cycle IDLE, `csr_we`=0, no redirect, `busy`=0.
- With `TRAP_TIMER_IRQ_EN`: `tmr_we` with 20 right after reset, MIE=1, `commit_valid` held → trap with mcause 0x80000007 accepted at the first cycle `mtime`≥20.

Source files
------------

// File: rtl/trap_pkg.sv
// Shared constants, FSM state type and CSR read-address decode for the trap sequencer.
// The optional machine timer interrupt source is enabled with TRAP_TIMER_IRQ_EN.
package trap_pkg;

  localparam int unsigned CSR_AW = 12;
  localparam int unsigned TMR_W  = 32;

  localparam logic [CSR_AW-1:0] CSR_MSTATUS = 12'h300;
  localparam logic [CSR_AW-1:0] CSR_MTVEC   = 12'h305;
  localparam logic [CSR_AW-1:0] CSR_MEPC    = 12'h341;
  localparam logic [CSR_AW-1:0] CSR_MCAUSE  = 12'h342;

  localparam int unsigned MSTATUS_MIE    = 3;
  localparam int unsigned MSTATUS_MPIE   = 7;
  localparam int unsigned MSTATUS_MPP_LO = 11;
  localparam int unsigned MSTATUS_MPP_HI = 12;

  // Interrupt cause codes; the interrupt flag is the MSB of mcause.
  localparam int unsigned IRQ_CODE_EXT = 11;
  localparam int unsigned IRQ_CODE_TMR = 7;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SAVE_EPC,
    ST_SAVE_CAUSE,
    ST_SAVE_STATUS,
    ST_JUMP,
    ST_RST_STATUS,
    ST_RET
  } trap_state_e;

  // mstatus is pre-read in SAVE_CAUSE so the SAVE_STATUS write data can be registered.
  function automatic logic [CSR_AW-1:0] f_raddr(input trap_state_e s);
    logic [CSR_AW-1:0] a;
    a = CSR_MSTATUS;
    case (s)
      ST_JUMP: a = CSR_MTVEC;
      ST_RET:  a = CSR_MEPC;
      default: a = CSR_MSTATUS;
    endcase
    return a;
  endfunction

endpackage

// File: rtl/trap_timer.sv
// Free-running mtime with writable mtimecmp; raises a level timer-pending flag.
// Only instantiated when TRAP_TIMER_IRQ_EN is defined.
module trap_timer
  import trap_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             i_tmr_we,
  input  logic [TMR_W-1:0] i_tmr_wdata,
  output logic             o_timer_pend_c
);

  logic [TMR_W-1:0] r_mtime;
  logic [TMR_W-1:0] r_mtimecmp;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mtime    <= '0;
      r_mtimecmp <= '1;
    end else begin
      r_mtime <= r_mtime + TMR_W'(1);
      if (i_tmr_we) begin
        r_mtimecmp <= i_tmr_wdata;
      end
    end
  end

  assign o_timer_pend_c = (r_mtime >= r_mtimecmp);

endmodule

// File: rtl/trap_ctrl.sv
// Trap entry/exit sequencer: stalls the core, writes mepc/mcause/mstatus in order, then redirects.
// Define TRAP_TIMER_IRQ_EN to add the mtime/mtimecmp timer interrupt source and its write port.
module trap_ctrl
  import trap_pkg::*;
#(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned CAUSE_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               commit_valid,
  input  logic [XLEN-1:0]    commit_pc,
  input  logic               exc_valid,
  input  logic [CAUSE_W-1:0] exc_cause,
  input  logic [XLEN-1:0]    exc_pc,
  input  logic               mret_valid,
  input  logic               irq_ext,
  output logic               csr_we,
  output logic [CSR_AW-1:0]  csr_waddr,
  output logic [XLEN-1:0]    csr_wdata,
  output logic [CSR_AW-1:0]  csr_raddr,
  input  logic [XLEN-1:0]    csr_rdata,
  output logic               redirect_valid,
  output logic [XLEN-1:0]    redirect_pc,
`ifdef TRAP_TIMER_IRQ_EN
  input  logic               tmr_we,
  input  logic [XLEN-1:0]    tmr_wdata,
`endif
  output logic               busy
);

  localparam logic [XLEN-1:0] CAUSE_IRQ_EXT = {1'b1, (XLEN-1)'(IRQ_CODE_EXT)};
  localparam logic [XLEN-1:0] CAUSE_IRQ_TMR = {1'b1, (XLEN-1)'(IRQ_CODE_TMR)};

  trap_state_e     r_state;
  logic [XLEN-1:0] r_epc;
  logic [XLEN-1:0] r_cause;
  logic            w_mie_now;
  logic            w_timer_pend;
  logic            w_take_irq_ext;
  logic            w_take_irq_tmr;

`ifdef TRAP_TIMER_IRQ_EN
  trap_timer u_timer (
    .clk            (clk),
    .rst            (rst),
    .i_tmr_we       (tmr_we),
    .i_tmr_wdata    (TMR_W'(tmr_wdata)),
    .o_timer_pend_c (w_timer_pend)
  );
`else
  assign w_timer_pend = 1'b0;
`endif

  // Stack MIE into MPIE, disable interrupts, record machine mode as previous privilege.
  function automatic logic [XLEN-1:0] f_entry_status(input logic [XLEN-1:0] s);
    logic [XLEN-1:0] r;
    r                                = s;
    r[MSTATUS_MPIE]                  = s[MSTATUS_MIE];
    r[MSTATUS_MIE]                   = 1'b0;
    r[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
    return r;
  endfunction

  // Restore MIE from MPIE and re-arm MPIE.
  function automatic logic [XLEN-1:0] f_return_status(input logic [XLEN-1:0] s);
    logic [XLEN-1:0] r;
    r               = s;
    r[MSTATUS_MIE]  = s[MSTATUS_MPIE];
    r[MSTATUS_MPIE] = 1'b1;
    return r;
  endfunction

  assign w_mie_now      = csr_rdata[MSTATUS_MIE];
  assign w_take_irq_ext = commit_valid & w_mie_now & irq_ext;
  assign w_take_irq_tmr = commit_valid & w_mie_now & w_timer_pend;

  // Sequencer state, latched trap frame and registered CSR/redirect strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= ST_IDLE;
      r_epc          <= '0;
      r_cause        <= '0;
      csr_we         <= 1'b0;
      csr_waddr      <= '0;
      csr_wdata      <= '0;
      redirect_valid <= 1'b0;
      busy           <= 1'b0;
    end else begin
      csr_we         <= 1'b0;
      redirect_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (exc_valid || w_take_irq_ext || w_take_irq_tmr) begin
            r_state   <= ST_SAVE_EPC;
            busy      <= 1'b1;
            csr_we    <= 1'b1;
            csr_waddr <= CSR_MEPC;
            if (exc_valid) begin
              r_epc     <= exc_pc;
              r_cause   <= XLEN'(exc_cause);
              csr_wdata <= exc_pc;
            end else if (w_take_irq_ext) begin
              r_epc     <= commit_pc;
              r_cause   <= CAUSE_IRQ_EXT;
              csr_wdata <= commit_pc;
            end else begin
              r_epc     <= commit_pc;
              r_cause   <= CAUSE_IRQ_TMR;
              csr_wdata <= commit_pc;
            end
          end else if (mret_valid) begin
            r_state   <= ST_RST_STATUS;
            busy      <= 1'b1;
            csr_we    <= 1'b1;
            csr_waddr <= CSR_MSTATUS;
            csr_wdata <= f_return_status(csr_rdata);
          end else begin
            busy <= 1'b0;
          end
        end
        ST_SAVE_EPC: begin
          r_state   <= ST_SAVE_CAUSE;
          csr_we    <= 1'b1;
          csr_waddr <= CSR_MCAUSE;
          csr_wdata <= r_cause;
        end
        ST_SAVE_CAUSE: begin
          r_state   <= ST_SAVE_STATUS;
          csr_we    <= 1'b1;
          csr_waddr <= CSR_MSTATUS;
          csr_wdata <= f_entry_status(csr_rdata);
        end
        ST_SAVE_STATUS: begin
          r_state        <= ST_JUMP;
          redirect_valid <= 1'b1;
        end
        ST_RST_STATUS: begin
          r_state        <= ST_RET;
          redirect_valid <= 1'b1;
        end
        ST_JUMP, ST_RET: begin
          r_state <= ST_IDLE;
          busy    <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

  // Read address follows the state; redirect target is taken straight from the CSR read port.
  always_comb begin
    csr_raddr   = f_raddr(r_state);
    redirect_pc = '0;
    if (r_state == ST_JUMP || r_state == ST_RET) begin
      redirect_pc = csr_rdata & ~XLEN'(3);
    end
  end

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed bench for trap_ctrl: a CSR-file model serves reads, and a timeline model of the
// trap rules predicts the per-cycle strobes that one compare process checks.
module tb_trap_ctrl;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned CAUSE_W = 4;
  localparam int          NCYC    = 2048;

  logic              clk = 1'b0;
  logic              rst;
  logic              commit_valid;
  logic [XLEN-1:0]   commit_pc;
  logic              exc_valid;
  logic [CAUSE_W-1:0] exc_cause;
  logic [XLEN-1:0]   exc_pc;
  logic              mret_valid;
  logic              irq_ext;
  logic              csr_we;
  logic [11:0]       csr_waddr;
  logic [XLEN-1:0]   csr_wdata;
  logic [11:0]       csr_raddr;
  logic [XLEN-1:0]   csr_rdata;
  logic              redirect_valid;
  logic [XLEN-1:0]   redirect_pc;
  logic              busy;
`ifdef TRAP_TIMER_IRQ_EN
  logic              tmr_we;
  logic [XLEN-1:0]   tmr_wdata;
`endif

  always #5 clk = ~clk;

  trap_ctrl #(.XLEN(XLEN), .CAUSE_W(CAUSE_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .commit_valid   (commit_valid),
    .commit_pc      (commit_pc),
    .exc_valid      (exc_valid),
    .exc_cause      (exc_cause),
    .exc_pc         (exc_pc),
    .mret_valid     (mret_valid),
    .irq_ext        (irq_ext),
    .csr_we         (csr_we),
    .csr_waddr      (csr_waddr),
    .csr_wdata      (csr_wdata),
    .csr_raddr      (csr_raddr),
    .csr_rdata      (csr_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
`ifdef TRAP_TIMER_IRQ_EN
    .tmr_we         (tmr_we),
    .tmr_wdata      (tmr_wdata),
`endif
    .busy           (busy)
  );

  // CSR file model: combinational read, write on the clock edge, plus a bench preset port.
  logic [31:0] m_mstatus = 32'h0000_0008;
  logic [31:0] m_mtvec   = 32'h8000_0100;
  logic [31:0] m_mepc    = 32'h0;
  logic [31:0] m_mcause  = 32'h0;
  logic        pre_en    = 1'b0;
  logic [11:0] pre_a     = 12'h0;
  logic [31:0] pre_v     = 32'h0;

  always_comb begin
    case (csr_raddr)
      12'h300: csr_rdata = m_mstatus;
      12'h305: csr_rdata = m_mtvec;
      12'h341: csr_rdata = m_mepc;
      12'h342: csr_rdata = m_mcause;
      default: csr_rdata = 32'h0;
    endcase
  end

  always @(posedge clk) begin
    if (csr_we) begin
      case (csr_waddr)
        12'h300: m_mstatus <= csr_wdata;
        12'h305: m_mtvec   <= csr_wdata;
        12'h341: m_mepc    <= csr_wdata;
        12'h342: m_mcause  <= csr_wdata;
        default: ;
      endcase
    end
    if (pre_en) begin
      case (pre_a)
        12'h300: m_mstatus <= pre_v;
        12'h341: m_mepc    <= pre_v;
        default: ;
      endcase
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

`ifdef TRAP_TIMER_IRQ_EN
  logic [31:0] m_mtime = 32'h0;
  logic [31:0] m_cmp   = 32'hFFFF_FFFF;
  always @(posedge clk) begin
    if (rst) begin
      m_mtime <= 32'h0;
      m_cmp   <= 32'hFFFF_FFFF;
    end else begin
      m_mtime <= m_mtime + 32'h1;
      if (tmr_we) m_cmp <= tmr_wdata;
    end
  end
`endif

  // Expected per-cycle outputs, filled in by the model when an event is presented.
  logic        exp_busy [NCYC];
  logic        exp_we   [NCYC];
  logic        exp_rv   [NCYC];
  logic        exp_rst  [NCYC];
  logic [11:0] exp_wa   [NCYC];
  logic [31:0] exp_wd   [NCYC];
  logic [31:0] exp_rpc  [NCYC];

  int          free_at     = 0;
  int          chk_from    = 1 << 30;
  int          n_chk       = 0;
  int          n_err       = 0;
  int          n_redirect  = 0;
  int          n_busy_rise = 0;
  logic        prev_busy   = 1'b0;
  logic [31:0] last_rpc    = 32'h0;
  logic [31:0] rise_mtime  = 32'h0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cycle %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  task automatic sched_w(input int c, input logic [11:0] a, input logic [31:0] d);
    exp_we[c]   = 1'b1;
    exp_wa[c]   = a;
    exp_wd[c]   = d;
    exp_busy[c] = 1'b1;
  endtask

  task automatic model_entry(input int n, input logic [31:0] epc, input logic [31:0] cause);
    logic [31:0] ms;
    logic [31:0] ns;
    ms = m_mstatus;
    ns = (ms & ~32'h0000_1888) | (32'(ms[3]) << 7) | 32'h0000_1800;
    sched_w(n + 1, 12'h341, epc);
    sched_w(n + 2, 12'h342, cause);
    sched_w(n + 3, 12'h300, ns);
    exp_busy[n + 4] = 1'b1;
    exp_rv[n + 4]   = 1'b1;
    exp_rpc[n + 4]  = m_mtvec & ~32'h3;
    free_at         = n + 5;
  endtask

  task automatic model_mret(input int n);
    logic [31:0] ms;
    logic [31:0] ns;
    ms = m_mstatus;
    ns = (ms & ~32'h0000_0088) | (32'(ms[7]) << 3) | 32'h0000_0080;
    sched_w(n + 1, 12'h300, ns);
    exp_busy[n + 2] = 1'b1;
    exp_rv[n + 2]   = 1'b1;
    exp_rpc[n + 2]  = m_mepc & ~32'h3;
    free_at         = n + 3;
  endtask

  // Decide what the sequencer must do with the inputs currently presented in this cycle.
  task automatic predict(output logic acc);
    logic mie;
    logic tp;
    int   n;
    n   = cyc;
    acc = 1'b0;
    mie = m_mstatus[3];
`ifdef TRAP_TIMER_IRQ_EN
    tp = (m_mtime >= m_cmp);
`else
    tp = 1'b0;
`endif
    if (n >= free_at) begin
      if (exc_valid) begin
        model_entry(n, exc_pc, 32'(exc_cause)); acc = 1'b1;
      end else if (commit_valid && mie && irq_ext) begin
        model_entry(n, commit_pc, 32'h8000_000B); acc = 1'b1;
      end else if (commit_valid && mie && tp) begin
        model_entry(n, commit_pc, 32'h8000_0007); acc = 1'b1;
      end else if (mret_valid) begin
        model_mret(n); acc = 1'b1;
      end
    end
  endtask

  task automatic model_reset(input int r);
    for (int c = r + 1; c < r + 10; c++) begin
      exp_busy[c] = 1'b0; exp_we[c] = 1'b0; exp_rv[c] = 1'b0; exp_rst[c] = 1'b0;
    end
    exp_rst[r + 1] = 1'b1;
    free_at        = r + 1;
  endtask

  task automatic compare_cycle();
    if (cyc >= chk_from && cyc < NCYC) begin
      chk("busy", 32'(busy), 32'(exp_busy[cyc]));
      chk("csr_we", 32'(csr_we), 32'(exp_we[cyc]));
      chk("redirect_valid", 32'(redirect_valid), 32'(exp_rv[cyc]));
      if (exp_we[cyc]) begin
        chk("csr_waddr", 32'(csr_waddr), 32'(exp_wa[cyc]));
        chk("csr_wdata", csr_wdata, exp_wd[cyc]);
      end
      if (exp_rv[cyc]) chk("redirect_pc", redirect_pc, exp_rpc[cyc]);
      if (exp_rst[cyc]) begin
        chk("reset_waddr", 32'(csr_waddr), 32'h0);
        chk("reset_wdata", csr_wdata, 32'h0);
        chk("reset_redirect_pc", redirect_pc, 32'h0);
      end
      if (redirect_valid) begin
        last_rpc = redirect_pc;
        n_redirect++;
      end
      if (busy && !prev_busy) begin
        n_busy_rise++;
`ifdef TRAP_TIMER_IRQ_EN
        rise_mtime = m_mtime;
`endif
      end
      prev_busy = busy;
    end
  endtask

  task automatic clear_inputs();
    commit_valid = 1'b0; commit_pc = '0; exc_valid = 1'b0; exc_cause = '0;
    exc_pc = '0; mret_valid = 1'b0; irq_ext = 1'b0;
  endtask

  task automatic drive(input logic exc, input logic [3:0] ec, input logic [31:0] epc,
                       input logic cv, input logic [31:0] cpc, input logic mr, input logic irq);
    logic acc;
    @(negedge clk);
    exc_valid = exc; exc_cause = ec; exc_pc = epc;
    commit_valid = cv; commit_pc = cpc; mret_valid = mr; irq_ext = irq;
    predict(acc);
    @(negedge clk);
    clear_inputs();
  endtask

  task automatic preset(input logic [11:0] a, input logic [31:0] v);
    @(negedge clk);
    pre_en = 1'b1; pre_a = a; pre_v = v;
    @(negedge clk);
    pre_en = 1'b0;
  endtask

  task automatic idle(input int k);
    repeat (k) @(negedge clk);
  endtask

  initial begin
    int busy_before;
    int rd_before;
    logic acc;
    for (int c = 0; c < NCYC; c++) begin
      exp_busy[c] = 1'b0; exp_we[c] = 1'b0; exp_rv[c] = 1'b0; exp_rst[c] = 1'b0;
      exp_wa[c] = '0; exp_wd[c] = '0; exp_rpc[c] = '0;
    end
    rst = 1'b1;
    clear_inputs();
`ifdef TRAP_TIMER_IRQ_EN
    tmr_we = 1'b0; tmr_wdata = '0;
`endif
    fork
      forever begin
        @(negedge clk);
        compare_cycle();
      end
    join_none

    repeat (4) @(negedge clk);
    model_reset(cyc);
    chk_from = cyc + 1;
    @(negedge clk);
    rst = 1'b0;
    idle(2);

    // ECALL from 0x80000040 with mstatus = 0x8.
    drive(1'b1, 4'hB, 32'h8000_0040, 1'b0, 32'h0, 1'b0, 1'b0);
    idle(6);
    chk("ecall_mepc", m_mepc, 32'h8000_0040);
    chk("ecall_mcause", m_mcause, 32'h0000_000B);
    chk("ecall_mstatus", m_mstatus, 32'h0000_1880);
    chk("ecall_target", last_rpc, 32'h8000_0100);

    // mret with mstatus = 0x1880 and mepc = 0x80000044.
    preset(12'h341, 32'h8000_0044);
    idle(1);
    drive(1'b0, 4'h0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);
    idle(4);
    chk("mret_mstatus", m_mstatus, 32'h0000_1888);
    chk("mret_target", last_rpc, 32'h8000_0044);

    // External interrupt with MIE set.
    preset(12'h300, 32'h0000_0008);
    idle(1);
    drive(1'b0, 4'h0, 32'h0, 1'b1, 32'h8000_0010, 1'b0, 1'b1);
    idle(6);
    chk("irq_mcause", m_mcause, 32'h8000_000B);
    chk("irq_mepc", m_mepc, 32'h8000_0010);

    // External interrupt with MIE clear: nothing happens.
    preset(12'h300, 32'h0000_0000);
    idle(1);
    busy_before = n_busy_rise;
    drive(1'b0, 4'h0, 32'h0, 1'b1, 32'h8000_0014, 1'b0, 1'b1);
    idle(6);
    chk("masked_irq_busy_rises", 32'(n_busy_rise), 32'(busy_before));
    chk("masked_irq_mcause", m_mcause, 32'h8000_000B);

    // Exception, mret and interrupt together: exception wins.
    preset(12'h300, 32'h0000_0008);
    idle(1);
    drive(1'b1, 4'h2, 32'h8000_0080, 1'b1, 32'h8000_0090, 1'b1, 1'b1);
    idle(6);
    chk("prio_mcause", m_mcause, 32'h0000_0002);
    chk("prio_mepc", m_mepc, 32'h8000_0080);
    chk("prio_mstatus", m_mstatus, 32'h0000_1880);

    // Reset while in SAVE_CAUSE: frame stays partial, no mstatus write, no redirect.
    preset(12'h300, 32'h0000_0008);
    idle(1);
    rd_before = n_redirect;
    drive(1'b1, 4'h5, 32'h8000_00C0, 1'b0, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    model_reset(cyc);
    @(negedge clk);
    rst = 1'b0;
    idle(6);
    chk("rst_mepc", m_mepc, 32'h8000_00C0);
    chk("rst_mcause", m_mcause, 32'h0000_0005);
    chk("rst_mstatus", m_mstatus, 32'h0000_0008);
    chk("rst_no_redirect", 32'(n_redirect), 32'(rd_before));

`ifdef TRAP_TIMER_IRQ_EN
    // Timer interrupt: mtimecmp = 20 written right after reset, commit held.
    @(negedge clk);
    rst = 1'b1;
    model_reset(cyc);
    @(negedge clk);
    rst = 1'b0;
    tmr_we = 1'b1; tmr_wdata = 32'd20;
    commit_valid = 1'b1; commit_pc = 32'h8000_0200;
    predict(acc);
    for (int i = 0; i < 60 && !acc; i++) begin
      @(negedge clk);
      tmr_we = 1'b0;
      predict(acc);
    end
    chk("timer_accept_bound", 32'(acc), 32'h1);
    @(negedge clk);
    clear_inputs();
    idle(6);
    chk("timer_mcause", m_mcause, 32'h8000_0007);
    chk("timer_mepc", m_mepc, 32'h8000_0200);
    chk("timer_busy_rise_mtime", rise_mtime, 32'd21);
`endif

    idle(2);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
